single_cycle_datapath: RTL and testbench
========================================

Name: single_cycle_datapath

Overview:
- Single-cycle RV32I core: one instruction fetched, decoded, executed and retired per clk rising edge.
- Contains PC register, instruction memory, 32x32 register file, immediate generator, ALU, branch comparator and data memory.
- Top-level processor block; the bench preloads registers and memories hierarchically.
- Instance and array names are fixed: reg_file_0.registers[0:31], inst_mem_0.memory[], data_mem_0.memory[].

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words.
- DMEM_DEPTH, 256, data memory depth in 32-bit words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- pc_o  output  32  current PC, for observability.

Behaviour:
- Reset asserted (low): PC=0 immediately, pc_o=0.
- Reset does not clear the register file or either memory, so preloaded contents survive reset.
- Each rising edge with reset high: commit rd write, data-memory store and PC update of the instruction at the current PC.
- Fetch: instr = inst_mem_0.memory[PC[31:2]], combinational; PC is a byte address, sequential next PC = PC+4.
- Register file: 2 combinational read ports, 1 synchronous write port.
  - x0 reads 0; writes to x0 are ignored.
- Immediates are sign-extended per RISC-V I/S/B/U/J formats.
- R-type (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shift amount is rs2[4:0].
  - SLT/SLTU write 1 or 0.
- I-ALU (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Shift amount is imm[4:0]; instr[30] selects SRAI.
- Load (0000011): rd = data_mem_0.memory[rs1+imm].
  - The ALU result is used directly as a word index (low bits, modulo DMEM_DEPTH), not divided by 4.
  - Every funct3 behaves as LW.
- Store (0100011): data_mem_0.memory[rs1+imm] = rs2 at the clock edge, same indexing as loads.
  - Every funct3 behaves as SW.
- Branch (1100011): BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Taken: PC = PC + imm_B; otherwise PC+4.
- LUI: rd = imm_U.
- AUIPC: rd = PC + imm_U.
- JAL: rd = PC+4; PC = PC + imm_J.
- JALR: rd = PC+4; PC = (rs1+imm_I) & ~1.
  - rs1 is read before the rd write, so rd==rs1 is safe.
- Any unrecognised opcode, including 0x00000000: NOP (no register write, no store, PC+4).
- Memories have no reset and no bounds fault; indices wrap modulo depth.
- Arithmetic is 32-bit two's complement; overflow is ignored.

Test Plan:
- Preload x1..x10 = 2,4,...,20 and dmem[0..4] = 5,10,20,30,40; release reset; execute in order:
  - ADD x1,x2,x3 -> x1=0x0A
  - SUB x4,x5,x6 -> x4=0xFFFFFFFE
  - OR x1,x9,x10 -> x1=0x16
  - SLL x1,x6,x7 -> x1=0x00030000
  - SRA x1,x8,x9 -> x1=0
  - SLT x1,x5,x6 -> x1=1
- I-type:
  - ADDI x1,x2,100 -> 0x68
  - SLTI x1,x3,5 -> 0
  - ANDI x1,x5,255 -> 0x0A
  - SRAI x1,x8,2 -> 4
  - LW x1,3(x0) -> x1=0x1E
- SW x6,2(x0) -> dmem[2]=0x0C; check after ~13 post-reset cycles.
- Branches:
  - BEQ x6,x7,+8 at PC 48 -> not taken, PC=52.
  - BNE x6,x7,+8 at PC 52 -> taken, PC=60; the ADD at 56 must not execute.
- U/J sequence:
  - LUI x1,0x12345 -> 0x12345000
  - AUIPC x1,0x12345 at PC 64 -> 0x12345040
  - JAL x10,+8 at 68 -> x10=72, PC=76
  - ADD at 76 -> x1=0x0A
  - JALR x1,0(x10) at 80 -> x1=84, PC=72
  - JAL x1,+12 at 72 -> x1=76, PC=84
  - Zero words beyond execute as NOPs.
- Drive reset low mid-run -> PC=0 asynchronously before the next edge; register and memory contents unchanged; execution restarts at instruction 0 after release.

Source files
------------

// File: rtl/single_cycle_datapath.sv
// Single-cycle RV32I core: fetch, decode, execute and retire one instruction per clk edge.
// Ports: clk   - system clock, all state updates on rising edge
//        reset - asynchronous active-low reset (PC forced to 0 while low)
//        pc_o  - current program counter (byte address)
// Register file and memories have no reset; their contents survive reset.

// 32x32 register file: two combinational read ports, one synchronous write port.
module reg_file (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] registers [0:31];

  // x0 is hardwired to zero on read regardless of array contents
  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : registers[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : registers[raddr2_i];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != 5'd0)) begin
      registers[waddr_i] <= wdata_i;
    end
  end
endmodule

// Instruction memory: combinational word read; load port is tied off inside the core.
module inst_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_data_i,
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] memory [DEPTH];

  assign rdata_o = memory[addr_i];

  always_ff @(posedge clk) begin
    if (load_we_i) begin
      memory[load_addr_i] <= load_data_i;
    end
  end
endmodule

// Data memory: combinational word read, synchronous word write, word-indexed.
module data_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] memory [DEPTH];

  assign rdata_o = memory[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i;
    end
  end
endmodule

module single_cycle_datapath #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_o
);
  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  logic [31:0]    pc_q, pc_d, pc_plus4;
  logic [31:0]    instr;
  logic [6:0]     opcode;
  logic [4:0]     rd, rs1, rs2;
  logic [2:0]     funct3;
  logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]    rs1_data, rs2_data;
  logic [31:0]    rd_wdata, dm_rdata;
  logic           rd_we, dm_we, br_taken;
  logic [DAW-1:0] dm_addr;

  // Shared ALU for R-type and I-ALU; alt selects SUB/SRA
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_o     = pc_q;

  // Immediate generator (sign-extended RISC-V formats)
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Data address is a word index taken from the low bits of rs1+imm
  assign dm_addr = DAW'(rs1_data + ((opcode == OPC_STORE) ? imm_s : imm_i));

  inst_mem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) inst_mem_0 (
    .clk         (clk),
    .load_we_i   (1'b0),
    .load_addr_i ('0),
    .load_data_i (32'd0),
    .addr_i      (pc_q[IAW+1:2]),
    .rdata_o     (instr)
  );

  reg_file reg_file_0 (
    .clk      (clk),
    .we_i     (rd_we && reset),
    .waddr_i  (rd),
    .wdata_i  (rd_wdata),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  data_mem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) data_mem_0 (
    .clk     (clk),
    .we_i    (dm_we && reset),
    .addr_i  (dm_addr),
    .wdata_i (rs2_data),
    .rdata_o (dm_rdata)
  );

  // Branch comparator; undefined funct3 values fall through as not taken
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_data == rs2_data);
      3'b001:  br_taken = (rs1_data != rs2_data);
      3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_taken = (rs1_data <  rs2_data);
      3'b111:  br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  // Decode and writeback select; unknown opcodes retire as NOP
  always_comb begin
    rd_we    = 1'b0;
    rd_wdata = 32'd0;
    dm_we    = 1'b0;
    pc_d     = pc_plus4;
    case (opcode)
      OPC_R: begin
        rd_we    = 1'b1;
        rd_wdata = alu(funct3, instr[30], rs1_data, rs2_data);
      end
      OPC_I: begin
        rd_we    = 1'b1;
        rd_wdata = alu(funct3, (funct3 == 3'b101) && instr[30], rs1_data, imm_i);
      end
      OPC_LOAD: begin
        rd_we    = 1'b1;
        rd_wdata = dm_rdata;
      end
      OPC_STORE: dm_we = 1'b1;
      OPC_BRANCH: begin
        if (br_taken) pc_d = pc_q + imm_b;
      end
      OPC_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OPC_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + imm_u;
      end
      OPC_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_d     = pc_q + imm_j;
      end
      OPC_JALR: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_d     = (rs1_data + imm_i) & 32'hFFFF_FFFE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end
endmodule

// File: tb/tb_single_cycle_datapath.sv
// Self-checking bench for single_cycle_datapath: directed program, async reset, random ISS compare.
module tb_single_cycle_datapath;
  localparam int unsigned IMEM = 256;
  localparam int unsigned DMEM = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural reference state
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [DMEM];
  logic [31:0] m_imem [IMEM];
  logic [31:0] m_pc;

  single_cycle_datapath #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM)) dut (
    .clk   (clk),
    .reset (reset),
    .pc_o  (pc_o)
  );

  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
      input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3);
    return {im[11:5], s2, s1, f3, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3);
    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] d,
      input logic [6:0] op);
    return {im, d, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
    return {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
  endfunction

  // Reference ALU from the instruction semantics
  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
      input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = int'(b % 32);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Execute one instruction on the reference state
  task automatic model_step();
    logic [31:0] ins, a, b, res, npc, ii, is, ib, iu, ij;
    logic [4:0]  d;
    logic [2:0]  f3;
    logic        wr, tk;
    ins = m_imem[(m_pc >> 2) % IMEM];
    d   = ins[11:7];
    f3  = ins[14:12];
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    ii  = 32'($signed(ins[31:20]));
    is  = 32'($signed({ins[31:25], ins[11:7]}));
    ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    iu  = {ins[31:12], 12'h000};
    ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    npc = m_pc + 32'd4;
    wr  = 1'b0;
    res = 32'd0;
    case (ins[6:0])
      7'h33: begin wr = 1'b1; res = ref_alu(f3, ins[30], a, b); end
      7'h13: begin wr = 1'b1; res = ref_alu(f3, (f3 == 3'd5) && ins[30], a, ii); end
      7'h03: begin wr = 1'b1; res = m_dmem[(a + ii) % DMEM]; end
      7'h23: m_dmem[(a + is) % DMEM] = b;
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) npc = m_pc + ib;
      end
      7'h37: begin wr = 1'b1; res = iu; end
      7'h17: begin wr = 1'b1; res = m_pc + iu; end
      7'h6F: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + ij; end
      7'h67: begin wr = 1'b1; res = m_pc + 32'd4; npc = (a + ii) & 32'hFFFF_FFFE; end
      default: ;
    endcase
    if (wr && d != 5'd0) m_regs[d] = res;
    m_pc = npc;
  endtask

  // Random but well-defined instruction
  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [2:0]  f3;
    logic        alt;
    logic [6:0]  junk [4];
    logic [2:0]  bf3 [6];
    junk = '{7'h00, 7'h7F, 7'h0B, 7'h5B};
    bf3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    w    = $urandom();
    f3   = w[14:12];
    alt  = w[30];
    case ($urandom_range(0, 9))
      0: begin
        w[31:25] = {1'b0, alt && (f3 == 3'd0 || f3 == 3'd5), 5'd0};
        w[6:0] = 7'h33;
      end
      1: begin
        if (f3 == 3'd1) w[31:25] = 7'd0;
        if (f3 == 3'd5) w[31:25] = {1'b0, alt, 5'd0};
        w[6:0] = 7'h13;
      end
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: begin w[14:12] = bf3[$urandom_range(0, 5)]; w[6:0] = 7'h63; end
      5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;
      7: w[6:0] = 7'h6F;
      8: begin w[14:12] = 3'd0; w[6:0] = 7'h67; end
      default: w[6:0] = junk[$urandom_range(0, 3)];
    endcase
    return w;
  endfunction

  task automatic load_all();
    for (int i = 0; i < int'(IMEM); i++) dut.inst_mem_0.memory[i] = m_imem[i];
    for (int i = 0; i < int'(DMEM); i++) dut.data_mem_0.memory[i] = m_dmem[i];
    for (int i = 0; i < 32; i++) dut.reg_file_0.registers[i] = m_regs[i];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #2;
    n_checks++;
    if (pc_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_pc: got %h expected %h", pc_o, 32'd0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (pc_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hold_pc: got %h expected %h", pc_o, 32'd0);
    end
  endtask

  task automatic test_directed();
    int unsigned t_rd  [22];
    logic [31:0] t_val [22];
    logic [31:0] t_pc  [22];
    logic [31:0] got;
    for (int i = 0; i < int'(IMEM); i++) m_imem[i] = 32'd0;
    for (int i = 0; i < int'(DMEM); i++) m_dmem[i] = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = (i <= 10) ? 32'(2 * i) : 32'd0;
    m_dmem[0] = 32'd5; m_dmem[1] = 32'd10; m_dmem[2] = 32'd20; m_dmem[3] = 32'd30; m_dmem[4] = 32'd40;
    m_imem[0]  = enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd1);
    m_imem[1]  = enc_r(7'h20, 5'd6, 5'd5, 3'd0, 5'd4);
    m_imem[2]  = enc_r(7'h00, 5'd10, 5'd9, 3'd6, 5'd1);
    m_imem[3]  = enc_r(7'h00, 5'd7, 5'd6, 3'd1, 5'd1);
    m_imem[4]  = enc_r(7'h20, 5'd9, 5'd8, 3'd5, 5'd1);
    m_imem[5]  = enc_r(7'h00, 5'd6, 5'd5, 3'd2, 5'd1);
    m_imem[6]  = enc_i(12'd100, 5'd2, 3'd0, 5'd1, 7'h13);
    m_imem[7]  = enc_i(12'd5, 5'd3, 3'd2, 5'd1, 7'h13);
    m_imem[8]  = enc_i(12'd255, 5'd5, 3'd7, 5'd1, 7'h13);
    m_imem[9]  = enc_i(12'h402, 5'd8, 3'd5, 5'd1, 7'h13);
    m_imem[10] = enc_i(12'd3, 5'd0, 3'd2, 5'd1, 7'h03);
    m_imem[11] = enc_s(12'd2, 5'd6, 5'd0, 3'd2);
    m_imem[12] = enc_b(13'd8, 5'd7, 5'd6, 3'd0);
    m_imem[13] = enc_b(13'd8, 5'd7, 5'd6, 3'd1);
    m_imem[14] = enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd11);
    m_imem[15] = enc_u(20'h12345, 5'd1, 7'h37);
    m_imem[16] = enc_u(20'h12345, 5'd1, 7'h17);
    m_imem[17] = enc_j(21'd8, 5'd10);
    m_imem[18] = enc_j(21'd12, 5'd1);
    m_imem[19] = enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd1);
    m_imem[20] = enc_i(12'd0, 5'd10, 3'd0, 5'd1, 7'h67);
    load_all();
    t_rd  = '{1, 4, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 10, 1, 1, 1, 0, 0};
    t_val = '{32'h0A, 32'hFFFF_FFFE, 32'h16, 32'h0003_0000, 32'h0, 32'h1, 32'h68, 32'h0,
              32'h0A, 32'h4, 32'h1E, 32'h0, 32'h0, 32'h0, 32'h1234_5000, 32'h1234_5040,
              32'd72, 32'h0A, 32'd84, 32'd76, 32'h0, 32'h0};
    t_pc  = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd36, 32'd40,
              32'd44, 32'd48, 32'd52, 32'd60, 32'd64, 32'd68, 32'd76, 32'd80, 32'd72, 32'd84,
              32'd88, 32'd92};
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < 22; s++) begin
      @(posedge clk); #1;
      n_checks++;
      if (pc_o !== t_pc[s]) begin
        n_fail++;
        $display("FAIL dir_pc step %0d: got %h expected %h", s, pc_o, t_pc[s]);
      end
      if (t_rd[s] != 0) begin
        got = dut.reg_file_0.registers[t_rd[s]];
        n_checks++;
        if (got !== t_val[s]) begin
          n_fail++;
          $display("FAIL dir_rd step %0d x%0d: got %h expected %h", s, t_rd[s], got, t_val[s]);
        end
      end
      if (s == 11) begin
        got = dut.data_mem_0.memory[2];
        n_checks++;
        if (got !== 32'h0C) begin
          n_fail++;
          $display("FAIL dir_sw dmem[2]: got %h expected %h", got, 32'h0C);
        end
      end
    end
    got = dut.reg_file_0.registers[11];
    n_checks++;
    if (got !== 32'd0) begin
      n_fail++;
      $display("FAIL dir_skipped_add x11: got %h expected %h", got, 32'd0);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] got;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (pc_o !== 32'd0) begin
      n_fail++;
      $display("FAIL async_pc: got %h expected %h", pc_o, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    got = dut.reg_file_0.registers[1];
    n_checks++;
    if (got !== 32'd76) begin
      n_fail++;
      $display("FAIL rst_keep x1: got %h expected %h", got, 32'd76);
    end
    got = dut.reg_file_0.registers[10];
    n_checks++;
    if (got !== 32'd72) begin
      n_fail++;
      $display("FAIL rst_keep x10: got %h expected %h", got, 32'd72);
    end
    got = dut.data_mem_0.memory[2];
    n_checks++;
    if (got !== 32'h0C) begin
      n_fail++;
      $display("FAIL rst_keep dmem[2]: got %h expected %h", got, 32'h0C);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (pc_o !== 32'd4) begin
      n_fail++;
      $display("FAIL restart_pc: got %h expected %h", pc_o, 32'd4);
    end
    got = dut.reg_file_0.registers[1];
    n_checks++;
    if (got !== 32'h0A) begin
      n_fail++;
      $display("FAIL restart x1: got %h expected %h", got, 32'h0A);
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < int'(IMEM); i++) m_imem[i] = gen_instr();
    for (int i = 0; i < int'(DMEM); i++) m_dmem[i] = $urandom();
    m_regs[0] = 32'd0;
    for (int i = 1; i < 32; i++) m_regs[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 600)) : $urandom();
    load_all();
    m_pc = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < 400; s++) begin
      model_step();
      @(posedge clk); #1;
      n_checks++;
      if (pc_o !== m_pc) begin
        n_fail++;
        $display("FAIL rnd_pc step %0d: got %h expected %h", s, pc_o, m_pc);
      end
      for (int r = 1; r < 32; r++) begin
        got = dut.reg_file_0.registers[r];
        n_checks++;
        if (got !== m_regs[r]) begin
          n_fail++;
          $display("FAIL rnd_reg step %0d x%0d: got %h expected %h", s, r, got, m_regs[r]);
        end
      end
    end
    for (int i = 0; i < int'(DMEM); i++) begin
      got = dut.data_mem_0.memory[i];
      n_checks++;
      if (got !== m_dmem[i]) begin
        n_fail++;
        $display("FAIL rnd_dmem[%0d]: got %h expected %h", i, got, m_dmem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
